// File: rtl/period_capture_unit.sv
// Measures the CLOCK-cycle interval between rising edges of EventIn and hands each
// result to a consumer over a Valid/Ack handshake, flagging saturation and lost samples.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  S_IDLE | disabled, counter held at zero
//  S_ARM  | enabled, waiting for the first edge to start timing
//  S_MEAS | timing the interval since the last edge; capture on each edge
module period_capture_unit #(
   parameter int length      = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLOCK,
   input  logic              Reset,
   input  logic              EventIn,
   input  logic              Enable,
   input  logic              Ack,
   output logic [length-1:0] Period,
   output logic              Valid,
   output logic              Overflow,
   output logic              Missed
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_MEAS = 2'd2
   } state_t;

   localparam logic [length-1:0] CNT_MAX = '1;
   localparam logic [length-1:0] CNT_ONE = length'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_dly_q;
   logic                   edge_pulse;

   state_t                 state_q;
   logic [length-1:0]      cnt_q;
   logic [length-1:0]      cnt_d;
   logic                   sat_q;
   logic [length-1:0]      period_q;
   logic                   valid_q;
   logic                   ovf_q;
   logic                   missed_q;

   always_ff @(posedge CLOCK or negedge Reset) begin
      if (!Reset) begin
         sync_q     <= '0;
         sync_dly_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], EventIn};
         sync_dly_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_pulse = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

   // Saturating increment; the counter parks at CNT_MAX until the next edge.
   assign cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

   always_ff @(posedge CLOCK or negedge Reset) begin
      if (!Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         period_q <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         // Handshake runs independently of Enable so a pending sample survives IDLE.
         if (state_q == S_MEAS && edge_pulse) begin
            period_q <= cnt_q;
            ovf_q    <= sat_q;
            valid_q  <= 1'b1;
            missed_q <= valid_q & ~Ack;
         end else if (valid_q && Ack) begin
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            missed_q <= 1'b0;
         end

         if (!Enable) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q <= S_ARM;
                  cnt_q   <= '0;
               end
               S_ARM: begin
                  if (edge_pulse) begin
                     state_q <= S_MEAS;
                     cnt_q   <= CNT_ONE;
                     sat_q   <= 1'b0;
                  end
               end
               S_MEAS: begin
                  if (edge_pulse) begin
                     cnt_q <= CNT_ONE;
                     sat_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_d;
                     if (cnt_d == CNT_MAX) sat_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  sat_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign Period   = period_q;
   assign Valid    = valid_q;
   assign Overflow = ovf_q;
   assign Missed   = missed_q;

endmodule

// File: tb/tb_period_capture_unit.sv
// Bench for period_capture_unit: directed scenarios plus randomized edge/ack/enable traffic,
// checked every cycle against an interval-arithmetic model of the block.
module tb_period_capture_unit;

   localparam int LEN  = 10;
   localparam int SYNC = 2;
   localparam int MAXV = (1 << LEN) - 1;

   logic           CLOCK = 1'b0;
   logic           Reset;
   logic           EventIn;
   logic           Enable;
   logic           Ack;
   logic [LEN-1:0] Period;
   logic           Valid;
   logic           Overflow;
   logic           Missed;

   period_capture_unit #(.length(LEN), .SYNC_STAGES(SYNC)) dut (
      .CLOCK   (CLOCK),
      .Reset   (Reset),
      .EventIn (EventIn),
      .Enable  (Enable),
      .Ack     (Ack),
      .Period  (Period),
      .Valid   (Valid),
      .Overflow(Overflow),
      .Missed  (Missed)
   );

   always #5 CLOCK = ~CLOCK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge CLOCK) cyc <= cyc + 1;

   // Model: each EventIn rise is seen by the block at a known later clock edge; the
   // reported period is simply the distance between successive seen edges.
   int edge_q[$];
   int m_phase = 0;      // 0 disabled, 1 waiting for first edge, 2 timing
   int last_edge = 0;
   int m_period = 0;
   bit m_valid = 0, m_ovf = 0, m_missed = 0;

   always @(posedge CLOCK or negedge Reset) begin
      if (!Reset) begin
         edge_q.delete();
         m_phase = 0; m_period = 0; m_valid = 0; m_ovf = 0; m_missed = 0;
      end else begin
         int  now;
         int  n;
         bit  seen;
         now  = cyc + 1;
         seen = 0;
         if (edge_q.size() > 0 && edge_q[0] == now) begin
            seen = 1;
            void'(edge_q.pop_front());
         end
         if (seen && m_phase == 2) begin
            n        = now - last_edge;
            m_period = (n >= MAXV) ? MAXV : n;
            m_ovf    = (n >= MAXV);
            m_missed = m_valid && !Ack;
            m_valid  = 1;
         end else if (m_valid && Ack) begin
            m_valid = 0; m_ovf = 0; m_missed = 0;
         end
         if (!Enable) m_phase = 0;
         else if (m_phase == 0) m_phase = 1;
         else if (seen) begin
            m_phase   = 2;
            last_edge = now;
         end
      end
   end

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   always @(negedge CLOCK) begin
      cmp("Period",   int'(Period),   m_period);
      cmp("Valid",    int'(Valid),    int'(m_valid));
      cmp("Overflow", int'(Overflow), int'(m_ovf));
      cmp("Missed",   int'(Missed),   int'(m_missed));
   end

   bit auto_ack = 0;
   bit rand_ack = 0;
   int last_rise = 0;

   task automatic tick();
      @(posedge CLOCK);
      #1;
      if (auto_ack) Ack = Valid & ~Ack;
      else if (rand_ack) Ack = ($urandom_range(0, 3) == 0);
   endtask

   task automatic rise();
      EventIn = 1'b1;
      edge_q.push_back(cyc + SYNC + 1);
      last_rise = cyc;
   endtask

   task automatic wave(input int n, input int hi);
      rise();
      repeat (hi) tick();
      EventIn = 1'b0;
      repeat (n - hi) tick();
   endtask

   task automatic at_cycle(input int t);
      while (cyc < t) tick();
   endtask

   task automatic pulse_settle();
      rise();
      tick();
      EventIn = 1'b0;
      repeat (9) tick();
   endtask

   task automatic ack_pulse();
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
   endtask

   task automatic restart();
      Enable = 1'b0;
      repeat (2) tick();
      Enable = 1'b1;
      repeat (2) tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      Reset = 1'b0; EventIn = 1'b0; Enable = 1'b0; Ack = 1'b0;
      repeat (3) tick();
      cmp("reset_valid",  int'(Valid),  0);
      cmp("reset_period", int'(Period), 0);
      Reset = 1'b1;
      tick();

      // Reset in the middle of a running measurement
      Enable = 1'b1;
      repeat (2) tick();
      repeat (3) wave(15, 3);
      cmp("pre_reset_period", int'(Period), 15);
      rise(); tick(); EventIn = 1'b0; repeat (7) tick();
      Reset = 1'b0;
      #1;
      cmp("async_reset_period", int'(Period), 0);
      cmp("async_reset_valid",  int'(Valid),  0);
      repeat (2) tick();
      Reset = 1'b1;
      repeat (3) tick();
      wave(15, 2);
      cmp("first_edge_only_arms", int'(Valid), 0);
      wave(15, 2);
      cmp("post_reset_period", int'(Period), 15);
      cmp("post_reset_valid",  int'(Valid),  1);
      ack_pulse();

      // 20-cycle square wave, consumer acks promptly
      restart();
      auto_ack = 1;
      wave(20, 10);
      cmp("square_first_edge_no_sample", int'(Valid), 0);
      repeat (5) wave(20, 10);
      auto_ack = 0;
      Ack = 1'b0;
      tick();
      cmp("square_period", int'(Period), 20);
      cmp("model_square_period", m_period, 20);
      cmp("square_missed", int'(Missed), 0);

      // Long gap saturates, then a normal interval
      restart();
      wave(1101, 1);
      r = cyc;
      pulse_settle();
      cmp("sat_period",   int'(Period),   MAXV);
      cmp("sat_overflow", int'(Overflow), 1);
      cmp("model_sat_overflow", int'(m_ovf), 1);
      ack_pulse();
      cmp("ack_clears_overflow", int'(Overflow), 0);
      cmp("ack_clears_valid",    int'(Valid),    0);
      at_cycle(r + 50);
      pulse_settle();
      cmp("after_sat_period",   int'(Period),   50);
      cmp("after_sat_overflow", int'(Overflow), 0);
      ack_pulse();

      // Saturation boundary: 1022 is exact, 1023 saturates
      restart();
      pulse_settle();
      r = last_rise;
      at_cycle(r + 1022);
      pulse_settle();
      cmp("n1022_period",   int'(Period),   1022);
      cmp("n1022_overflow", int'(Overflow), 0);
      ack_pulse();
      r = last_rise;
      at_cycle(r + 1023);
      pulse_settle();
      cmp("n1023_period",   int'(Period),   1023);
      cmp("n1023_overflow", int'(Overflow), 1);
      ack_pulse();

      // Uncollected samples are overwritten and flagged
      restart();
      pulse_settle();
      r = last_rise;
      at_cycle(r + 30);
      pulse_settle();
      cmp("first_sample_valid",  int'(Valid),  1);
      cmp("first_sample_missed", int'(Missed), 0);
      r = last_rise;
      at_cycle(r + 30);
      pulse_settle();
      cmp("overwrite_period", int'(Period), 30);
      cmp("overwrite_missed", int'(Missed), 1);
      ack_pulse();
      cmp("ack_clears_missed", int'(Missed), 0);
      cmp("ack_clears_valid2", int'(Valid),  0);

      // Ack coinciding with a capture
      r = last_rise;
      at_cycle(r + 25);
      pulse_settle();
      r = last_rise;
      at_cycle(r + 25);
      pulse_settle();
      cmp("missed_before_coincide", int'(Missed), 1);
      r = last_rise;
      at_cycle(r + 27);
      rise(); tick(); EventIn = 1'b0;
      at_cycle(last_rise + SYNC);
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
      cmp("coincide_valid",  int'(Valid),  1);
      cmp("coincide_missed", int'(Missed), 0);
      cmp("coincide_period", int'(Period), 27);

      // Enable gap with a sample pending
      r = last_rise;
      at_cycle(r + 10);
      Enable = 1'b0;
      at_cycle(r + 15);
      rise(); tick(); EventIn = 1'b0;
      at_cycle(r + 20);
      Enable = 1'b1;
      at_cycle(r + 30);
      pulse_settle();
      cmp("gap_pending_period", int'(Period), 27);
      cmp("gap_pending_valid",  int'(Valid),  1);
      at_cycle(r + 52);
      pulse_settle();
      cmp("gap_new_period", int'(Period), 22);
      cmp("gap_new_missed", int'(Missed), 1);
      ack_pulse();

      // Randomized traffic
      rand_ack = 1;
      for (int it = 0; it < 150; it++) begin
         int hi;
         int n;
         if ($urandom_range(0, 39) == 0) begin
            Reset = 1'b0;
            repeat (2) tick();
            Reset = 1'b1;
            tick();
         end
         hi = $urandom_range(1, 4);
         n  = ($urandom_range(0, 19) == 0) ? $urandom_range(1015, 1030)
                                           : hi + $urandom_range(1, 60);
         rise();
         repeat (hi) tick();
         EventIn = 1'b0;
         for (int k = 0; k < n - hi; k++) begin
            if ($urandom_range(0, 199) == 0) Enable = ~Enable;
            tick();
         end
      end
      rand_ack = 0;
      Ack = 1'b0;
      Enable = 1'b1;
      repeat (10) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
